// File: rtl/wavelet_synth_haar.sv
// Streaming inverse Haar stage: each (a, d) pair becomes two samples, a+d then a-d.
// Define WAVELET_SYNTH_SAT_EN to saturate results and drive sat_flag; otherwise results wrap.
module wavelet_synth_haar #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] approx_in,
  input  logic signed [DATA_W-1:0] detail_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] recon_ecg,
  output logic                     out_phase,
  output logic                     sat_flag
);

  typedef enum logic [1:0] {StEmpty, StEven, StOdd} state_e;

  state_e             state_q, state_d;
  logic               accept;
  logic               advance;
  logic [DATA_W-1:0]  recon_q;
  logic               phase_q;
  logic [DATA_W-1:0]  odd_q;
  logic [DATA_W-1:0]  sum_fit;
  logic [DATA_W-1:0]  diff_fit;

`ifdef WAVELET_SYNTH_SAT_EN
  localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] sum_w;
  logic signed [DATA_W:0] diff_w;
  logic                   sum_clip;
  logic                   diff_clip;
  logic                   sat_q;
  logic                   odd_sat_q;

  // One extra bit holds the exact result; top two bits disagree on overflow.
  always_comb begin
    sum_w     = approx_in + detail_in;
    diff_w    = approx_in - detail_in;
    sum_clip  = sum_w[DATA_W] ^ sum_w[DATA_W-1];
    diff_clip = diff_w[DATA_W] ^ diff_w[DATA_W-1];
    sum_fit   = sum_clip ? (sum_w[DATA_W] ? MinVal : MaxVal) : sum_w[DATA_W-1:0];
    diff_fit  = diff_clip ? (diff_w[DATA_W] ? MinVal : MaxVal) : diff_w[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_q     <= 1'b0;
      odd_sat_q <= 1'b0;
    end else if (accept) begin
      sat_q     <= sum_clip;
      odd_sat_q <= diff_clip;
    end else if (advance) begin
      sat_q     <= odd_sat_q;
    end
  end

  assign sat_flag = sat_q;
`else
  always_comb begin
    sum_fit  = approx_in + detail_in;
    diff_fit = approx_in - detail_in;
  end

  assign sat_flag = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StEven;
      StEven:  if (out_ready) state_d = StOdd;
      StOdd: begin
        if (accept) begin
          state_d = StEven;
        end else if (out_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Output / handshake logic
  always_comb begin
    in_ready  = !reset && ((state_q == StEmpty) || ((state_q == StOdd) && out_ready));
    out_valid = !reset && ((state_q == StEven) || (state_q == StOdd));
    accept    = in_valid && in_ready;
    advance   = (state_q == StEven) && out_ready;
  end

  // Presented sample; held whenever neither a new pair nor the odd half is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      recon_q <= '0;
      phase_q <= 1'b0;
      odd_q   <= '0;
    end else if (accept) begin
      recon_q <= sum_fit;
      phase_q <= 1'b0;
      odd_q   <= diff_fit;
    end else if (advance) begin
      recon_q <= odd_q;
      phase_q <= 1'b1;
    end
  end

  assign recon_ecg = recon_q;
  assign out_phase = phase_q;

endmodule

// File: tb/tb_wavelet_synth_haar.sv
// Directed self-checking bench for wavelet_synth_haar (DATA_W = 32).
module tb_wavelet_synth_haar;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] approx_in;
  logic signed [31:0] detail_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] recon_ecg;
  logic               out_phase;
  logic               sat_flag;

  int checks = 0;
  int errors = 0;

  wavelet_synth_haar #(.DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .approx_in (approx_in),
    .detail_in (detail_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .recon_ecg (recon_ecg),
    .out_phase (out_phase),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int val, input logic ph, input logic rdy);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"}, recon_ecg, 32'(val));
    check({tag, ".phase"}, 32'(out_phase), 32'(ph));
    check({tag, ".ready"}, 32'(in_ready), 32'(rdy));
  endtask

  task automatic send(input int a, input int d);
    in_valid  = 1'b1;
    approx_in = 32'(a);
    detail_in = 32'(d);
  endtask

  int exp_b2b [6] = '{12, 8, -10, 0, 7, -7};

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    approx_in = 32'sd5;
    detail_in = 32'sd5;
    out_ready = 1'b1;

    // Reset held three cycles with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst.in_ready", 32'(in_ready), 32'd0);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.recon", recon_ecg, 32'd0);
      check("rst.sat", 32'(sat_flag), 32'd0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 32'(in_ready), 32'd1);
    check("post_rst.out_valid", 32'(out_valid), 32'd0);

    // Basic pair
    send(100, 30);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("basic.even", 130, 1'b0, 1'b0);
    @(negedge clk);
    check_out("basic.odd", 70, 1'b1, 1'b1);
    @(negedge clk);
    check("basic.idle", 32'(out_valid), 32'd0);
    check("basic.hold", recon_ecg, 32'd70);

    // Back-to-back with out_ready high
    send(10, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out($sformatf("b2b[%0d]", i), exp_b2b[i], 1'(i % 2), 1'(i % 2));
      if (i == 0) send(-5, -5);
      if (i == 2) send(0, 7);
      if (i == 4) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b.idle", 32'(out_valid), 32'd0);

    // Back-pressure
    send(1000, -1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_out($sformatf("bp.hold[%0d]", i), 999, 1'b0, 1'b0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_out("bp.odd", 1001, 1'b1, 1'b1);
    @(negedge clk);
    check("bp.idle", 32'(out_valid), 32'd0);

    // Overflow on the even half
    send(32'h7FFF_FFF0, 32'h20);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef WAVELET_SYNTH_SAT_EN
    check_out("ovf.even", 32'h7FFF_FFFF, 1'b0, 1'b0);
    check("ovf.even.sat", 32'(sat_flag), 32'd1);
`else
    check_out("ovf.even", 32'h8000_0010, 1'b0, 1'b0);
    check("ovf.even.sat", 32'(sat_flag), 32'd0);
`endif
    @(negedge clk);
    check_out("ovf.odd", 32'h7FFF_FFD0, 1'b1, 1'b1);
    check("ovf.odd.sat", 32'(sat_flag), 32'd0);
    @(negedge clk);
    check("ovf.idle", 32'(out_valid), 32'd0);

    // Reset while holding the even half under back-pressure
    send(3, 4);
    out_ready = 1'b0;
    @(negedge clk);
    check_out("rmid.even", 7, 1'b0, 1'b0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rmid.out_valid", 32'(out_valid), 32'd0);
    check("rmid.recon", recon_ecg, 32'd0);
    check("rmid.in_ready", 32'(in_ready), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rmid.no_odd[%0d]", i), 32'(out_valid), 32'd0);
      check($sformatf("rmid.ready[%0d]", i), 32'(in_ready), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wavelet_synth_haar.md
# wavelet_synth_haar

Streaming inverse Haar wavelet (synthesis) stage for the QRS detector datapath. It takes one approximation/detail coefficient pair per transaction and reconstructs two consecutive ECG samples: even = a + d, odd = a − d. It sits downstream of the decomposition filter bank and rebuilds a time-domain ECG from the (possibly thresholded) coefficients, which is used for denoised display and for verification against the raw input. Input and output are valid/ready streams, and the output is emitted at twice the coefficient rate.

## Interface
- DATA_W, 32: width of the signed coefficients and reconstructed samples (two's complement).

- clk  input  1  sole clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  coefficient pair present on approx_in/detail_in
- in_ready  output  1  block accepts the pair this cycle
- approx_in  input  DATA_W  signed approximation coefficient a
- detail_in  input  DATA_W  signed detail coefficient d
- out_valid  output  1  recon_ecg holds a valid sample
- out_ready  input  1  downstream accepts recon_ecg this cycle
- recon_ecg  output  DATA_W  signed reconstructed sample (registered)
- out_phase  output  1  0 = even sample (a+d), 1 = odd sample (a−d)
- sat_flag  output  1  current recon_ecg was clipped (see Configuration)

## Operation
- FSM states:
  - EMPTY: no sample held.
  - EVEN: presenting a+d.
  - ODD: presenting a−d.
- Reset, and the first cycle after reset, put the FSM in EMPTY. While reset is high: out_valid=0, recon_ecg=0, out_phase=0, sat_flag=0, in_ready=0. Internal odd-hold register is cleared to 0.
- in_ready = !reset && (state==EMPTY || (state==ODD && out_ready)). The output side is never back-pressured by the input side.
- Accept (in_valid && in_ready):
  - Compute both results in DATA_W+1 bits: s = a+d, t = a−d.
  - recon_ecg ← fit(s), out_phase ← 0, sat_flag ← clip(s).
  - Odd-hold register ← fit(t), together with its clip bit.
  - state ← EVEN.
- EVEN with out_ready: recon_ecg ← odd-hold value, out_phase ← 1, sat_flag ← held clip bit, state ← ODD.
- ODD with out_ready:
  - If a pair is accepted the same cycle, go to EVEN with the new data (back-to-back, no bubble).
  - Otherwise out_valid ← 0 and state ← EMPTY. recon_ecg keeps its last value.
- out_valid = (state==EVEN || state==ODD).
- Back-pressure: while out_valid && !out_ready, recon_ecg, out_phase and sat_flag are held stable, and in_ready=0.
- fit(): see Configuration. No other scaling; the upstream analysis stage owns the ½ normalisation.
- Reset mid-transaction discards the held odd sample. No partial pair is emitted after reset.

## Timing
- Latency: pair accepted at edge N → even sample valid after edge N (visible in cycle N+1) → odd sample visible in the cycle after the even handshake.
- Peak throughput: one pair per 2 cycles, one sample per cycle, with out_ready held high and in_valid held high.
- in_ready is combinational from state, out_ready and reset. There is no combinational path from in_valid or the data inputs to any output.
- recon_ecg, out_phase and sat_flag are registers.

## Configuration
- WAVELET_SYNTH_SAT_EN defined:
  - fit() saturates the DATA_W+1 result to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - clip() = 1 when saturation occurred.
  - sat_flag follows the presented sample.
- WAVELET_SYNTH_SAT_EN undefined:
  - fit() truncates to the low DATA_W bits (wrap-around).
  - sat_flag is tied to 0.
  - No saturation logic is synthesised.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1. Required: in_ready=0, out_valid=0, recon_ecg=0 throughout; in_ready=1 in the first cycle after reset falls.
- Basic pair, out_ready=1: send a=100, d=30. Required output sequence (phase 0) 130 then (phase 1) 70, then out_valid=0.
- Back-to-back, in_valid and out_ready held high: send (10,2), (−5,−5), (0,7). Required: continuous output 12, 8, −10, 0, 7, −7 with no idle cycles; in_ready high every other cycle.
- Back-pressure: send (1000,−1) with out_ready=0 for 4 cycles. Required: recon_ecg=999, phase 0, held stable, in_ready=0. Then out_ready=1: next output 1001.
- Overflow, DATA_W=32: send a=0x7FFFFFF0, d=0x20.
  - Macro defined: 0x7FFFFFFF with sat_flag=1, then 0x7FFFFFD0 with sat_flag=0.
  - Macro undefined: 0x80000010, then 0x7FFFFFD0; sat_flag=0 on both.
- Reset mid-pair: assert reset while in EVEN with out_ready=0. Required: out_valid=0 in the next cycle and no odd sample is ever emitted.
